// File: rtl/dino_pkg.sv
// dino_pkg -- screen geometry and pixel-pipeline types shared by the ground
// renderer and its texture ROM.
//   H_ACTIVE / V_ACTIVE : visible pixels per line / visible lines
//   GROUND_Y / BAND_H   : first line and height (<= 16) of the ground band
//   TEX_W / TEX_AW      : texture period (power of two) and its column width
//   col_t / row_t       : texture column and band row types
package dino_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int GROUND_Y = 400;
   localparam int BAND_H   = 12;
   localparam int TEX_W    = 1024;
   localparam int TEX_AW   = $clog2(TEX_W);

   typedef logic [TEX_AW-1:0] col_t;
   typedef logic [3:0]        row_t;

endpackage

// File: rtl/ground_tex_rom.sv
// ground_tex_rom -- ground texture lookup; its registered output is stage 2 of
// the ground_render pixel pipeline. Only built with GROUND_RENDER_TEX_EN.
// Row 0 is the solid horizon line; other rows carry one pebble per 64-pixel
// tile at column row*4.
// Ports:
//   clk_25MHz : pixel clock, rising edge
//   row       : band row, 4 bits
//   col       : texture column, TEX_AW bits
//   texel     : registered texel for (row, col)
module ground_tex_rom #(
   parameter int TEX_AW = dino_pkg::TEX_AW
) (
   input  logic              clk_25MHz,
   input  logic [3:0]        row,
   input  logic [TEX_AW-1:0] col,
   output logic              texel
);

   // The pebble pattern repeats every 64 columns.
   localparam logic [TEX_AW-1:0] TILE_MASK = TEX_AW'(63);

   logic [TEX_AW-1:0] pebble_col;
   assign pebble_col = TEX_AW'({row, 2'b00});

   // NOTE: this data flop has no reset on purpose; whatever it holds after
   // reset is masked by the reset-cleared valid/band flops beside it.
   always_ff @(posedge clk_25MHz) begin
      texel <= (row == 4'd0) || ((col & TILE_MASK) == pebble_col);
   end

endmodule

// File: rtl/ground_render.sv
// ground_render -- ground band renderer in the VGA pixel clock domain.
// Latches the scroll offset from ground_state once per frame (tear-free) and
// turns the raster position into a ground pixel through a fixed 2-cycle
// pipeline.
// Configuration macro: GROUND_RENDER_TEX_EN -- when defined, band rows
// 1..BAND_H-1 come from ground_tex_rom; otherwise only the horizon line.
// Ports:
//   clk_25MHz   : pixel clock, all logic on its rising edge
//   rst_n       : asynchronous active-low reset
//   ground_x    : scroll offset from the clk_100Hz domain (asynchronous)
//   h_cnt/v_cnt : current raster column / line
//   frame_start : one-cycle pulse at the first blanking cycle of a frame
//   pixel_on    : ground pixel lit, aligned with h_out/v_out
//   pixel_valid : h_out/v_out lie in the active region
//   h_out/v_out : h_cnt/v_cnt delayed by 2 cycles
//   scroll_x    : offset in use for the current frame
//   miss_cnt    : saturating count of frames whose latch was skipped
module ground_render #(
   parameter int H_ACTIVE = dino_pkg::H_ACTIVE,
   parameter int V_ACTIVE = dino_pkg::V_ACTIVE,
   parameter int GROUND_Y = dino_pkg::GROUND_Y,
   parameter int BAND_H   = dino_pkg::BAND_H,
   parameter int TEX_W    = dino_pkg::TEX_W
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic [15:0] ground_x,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        frame_start,
   output logic        pixel_on,
   output logic        pixel_valid,
   output logic [9:0]  h_out,
   output logic [9:0]  v_out,
   output logic [15:0] scroll_x,
   output logic [7:0]  miss_cnt
);

   import dino_pkg::*;

   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
   localparam logic [9:0] Y_LO  = 10'(GROUND_Y);
   localparam logic [9:0] Y_HI  = 10'(GROUND_Y + BAND_H);

   // An illegal geometry never lights the band instead of drawing garbage.
   localparam bit CFG_OK = ((TEX_W & (TEX_W - 1)) == 0) && (TEX_W <= 65536) &&
                           (BAND_H <= 16);

   // ---------------------------------------------------------------------
   // Scroll capture. ground_x may change at any time relative to this clock;
   // a value is only taken when two consecutive samples agree.
   // ---------------------------------------------------------------------
   logic [15:0] s1, s2, s3;
   logic        stable;

   assign stable = (s2 == s3);

   // NOTE: sequential state is written with <= only, so every flop samples
   // the pre-edge values and the chain shifts by exactly one stage per edge.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         s3       <= '0;
         scroll_x <= '0;
         miss_cnt <= '0;
      end else begin
         s1 <= ground_x;
         s2 <= s1;
         s3 <= s2;
         if (frame_start) begin
            if (stable) begin
               scroll_x <= s2;
            end else if (miss_cnt != 8'hFF) begin
               miss_cnt <= miss_cnt + 8'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 1: raster decode. Uses the scroll_x value from before the edge,
   // so a pixel entering on a frame_start edge still sees the old offset.
   // ---------------------------------------------------------------------
   logic act_d, band_d;
   row_t row_d;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      act_d  = 1'b0;
      band_d = 1'b0;
      row_d  = '0;
      act_d  = (h_cnt < H_LIM) && (v_cnt < V_LIM);
      band_d = CFG_OK && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
      row_d  = 4'(v_cnt - Y_LO);
   end

   logic       act1, band1;
   row_t       row1;
   logic [9:0] h1, v1;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         act1  <= 1'b0;
         band1 <= 1'b0;
         row1  <= '0;
         h1    <= '0;
         v1    <= '0;
      end else begin
         act1  <= act_d;
         band1 <= band_d;
         row1  <= row_d;
         h1    <= h_cnt;
         v1    <= v_cnt;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: texel lookup alongside the delayed qualifiers and position.
   // ---------------------------------------------------------------------
   logic act2, band2, texel;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         act2  <= 1'b0;
         band2 <= 1'b0;
         h_out <= '0;
         v_out <= '0;
      end else begin
         act2  <= act1;
         band2 <= band1;
         h_out <= h1;
         v_out <= v1;
      end
   end

`ifdef GROUND_RENDER_TEX_EN
   localparam int AW = $clog2(TEX_W);

   // Column wraps modulo TEX_W; only the low AW bits of the add matter, so
   // 0xFFFF -> 0x0000 in ground_x needs no special case.
   logic [AW-1:0] col_d, col1;
   assign col_d = AW'(h_cnt) + AW'(scroll_x);

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         col1 <= '0;
      end else begin
         col1 <= col_d;
      end
   end

   ground_tex_rom #(
      .TEX_AW (AW)
   ) u_tex_rom (
      .clk_25MHz (clk_25MHz),
      .row       (row1),
      .col       (col1),
      .texel     (texel)
   );
`else
   // Plain horizon: only row 0 is lit. Kept as a register so the latency
   // matches the textured build.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         texel <= 1'b0;
      end else begin
         texel <= (row1 == 4'd0);
      end
   end
`endif

   // Both qualifiers are reset flops, so the outputs fall to 0 the moment
   // rst_n asserts.
   assign pixel_valid = act2;
   assign pixel_on    = act2 && band2 && texel;

endmodule
